// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the clearable single-port RAM.
package sp_ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   localparam int RDW_FIRST_READ  = 0;
   localparam int RDW_FIRST_WRITE = 1;

endpackage

// File: rtl/sp_ram_rdpipe.sv
// Read-data valid/data delay line, one or two register stages.
module sp_ram_rdpipe #(
   parameter int WIDTH      = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             zero_s1,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic             v1;
   logic [WIDTH-1:0] d1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            d1 <= in_data;
         end else if (zero_s1) begin
            d1 <= '0;
         end
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic             v2;
         logic [WIDTH-1:0] d2;

         // zero_s1 marks a stage-1 word whose address the sweep overwrites this edge
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v2 <= 1'b0;
               d2 <= '0;
            end else begin
               v2 <= v1;
               d2 <= zero_s1 ? '0 : d1;
            end
         end

         assign out_valid = v2;
         assign out_data  = d2;
      end else begin : g_lat1
         assign out_valid = v1;
         assign out_data  = d1;
      end
   endgenerate

endmodule

// File: rtl/sp_ram_clr.sv
// Single-port byte-writable RAM with a zeroing sweep after reset or on clr.
//
// state    | meaning
// ST_CLEAR | writing zero to mem[clr_cnt] each cycle, requests refused
// ST_IDLE  | accepting req; clr starts a sweep on the next edge
module sp_ram_clr
   import sp_ram_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int WIDTH      = 32,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH/8-1:0]       be,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     clr,
   output logic                     ready,
   output logic                     busy,
   output logic [WIDTH-1:0]         rdata,
   output logic                     rvalid
);

   localparam int              AW        = $clog2(DEPTH);
   localparam int              NB        = WIDTH / 8;
   localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
   localparam bit              RDW_ZERO  = (RDW_MODE != RDW_FIRST_READ) && (RD_LATENCY == 2);

   state_t           state, state_nxt;
   logic [AW-1:0]    clr_cnt, clr_cnt_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_acc, rd_acc;
   logic             rd_pend;
   logic [AW-1:0]    rd_addr_q;
   logic             zero_s1;

   assign ready  = (state == ST_IDLE);
   assign busy   = (state == ST_CLEAR);
   assign wr_acc = req && ready && we;
   assign rd_acc = req && ready && !we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         ST_CLEAR: begin
            if (clr_cnt == LAST_ADDR) begin
               state_nxt   = ST_IDLE;
               clr_cnt_nxt = '0;
            end else begin
               clr_cnt_nxt = clr_cnt + AW'(1);
            end
         end
         ST_IDLE: begin
            clr_cnt_nxt = '0;
            if (clr) begin
               state_nxt = ST_CLEAR;
            end
         end
         default: begin
            state_nxt   = ST_CLEAR;
            clr_cnt_nxt = '0;
         end
      endcase
   end

   // No reset on the array: contents are only ever zeroed by the sweep.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[clr_cnt] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend   <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         rd_pend <= rd_acc;
         if (rd_acc) begin
            rd_addr_q <= addr;
         end
      end
   end

   // Only a two-stage pipe can hold a read across a sweep write to its address.
   assign zero_s1 = RDW_ZERO && busy && rd_pend && (rd_addr_q == clr_cnt);

   sp_ram_rdpipe #(
      .WIDTH      (WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_rdpipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_acc),
      .in_data   (mem[addr]),
      .zero_s1   (zero_s1),
      .out_valid (rvalid),
      .out_data  (rdata)
   );

endmodule

// File: tb/tb_sp_ram_clr.sv
// Directed bench for sp_ram_clr: latency-1, latency-2 read-first, latency-2 write-first.
module tb_sp_ram_clr;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [3:0]  addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        clr;
   logic [2:0]  rdy, bsy, rv;
   logic [31:0] rd [3];

   int n_vec = 0;
   int n_err = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sp_ram_clr #(
         .DEPTH      (16),
         .WIDTH      (32),
         .RD_LATENCY ((g == 0) ? 1 : 2),
         .RDW_MODE   ((g == 2) ? 1 : 0)
      ) u_dut (
         .clk    (clk),
         .rst    (rst),
         .req    (req),
         .we     (we),
         .addr   (addr),
         .be     (be),
         .wdata  (wdata),
         .clr    (clr),
         .ready  (rdy[g]),
         .busy   (bsy[g]),
         .rdata  (rd[g]),
         .rvalid (rv[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic exp_rdy);
      chk({tag, " ready"}, {29'b0, rdy}, exp_rdy ? 32'h7 : 32'h0);
      chk({tag, " busy"},  {29'b0, bsy}, exp_rdy ? 32'h0 : 32'h7);
   endtask

   task automatic chk_rd(input string tag, input logic [2:0] ev,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
      logic [31:0] e [3];
      e[0] = e0; e[1] = e1; e[2] = e2;
      chk({tag, " rvalid"}, {29'b0, rv}, {29'b0, ev});
      for (int g = 0; g < 3; g++) begin
         if (ev[g]) chk($sformatf("%s rdata%0d", tag, g), rd[g], e[g]);
      end
   endtask

   task automatic drv(input logic r, input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] b, input logic c);
      req = r; we = w; addr = a; wdata = d; be = b; clr = c;
   endtask

   initial begin
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      chk_st("reset", 1'b0);
      chk_rd("reset", 3'b000, 0, 0, 0);
      for (int g = 0; g < 3; g++) chk($sformatf("reset rdata%0d", g), rd[g], 32'h0);

      // power-up sweep: ready only after the 16th edge
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk_st($sformatf("init_sweep%0d", k), k == 16);
      end

      for (int i = 0; i < 18; i++) begin
         drv(i < 16, 0, 4'(i), 0, 0, 0);
         tick();
         chk_rd($sformatf("init_rd%0d", i), {i >= 1 && i <= 16, i >= 1 && i <= 16, i < 16}, 0, 0, 0);
      end

      // byte-lane merge, then a be=0 write that must not change anything
      drv(1, 1, 3, 32'hDEADBEEF, 4'b1111, 0); tick();
      chk_rd("wr_no_rv", 3'b000, 0, 0, 0);
      drv(1, 1, 3, 32'h11223344, 4'b0101, 0); tick();
      drv(1, 1, 3, 32'hFFFFFFFF, 4'b0000, 0); tick();
      drv(1, 0, 3, 0, 0, 0); tick();
      chk_rd("be_rd_e1", 3'b001, 32'hDE22BE44, 0, 0);
      drv(0, 0, 0, 0, 0, 0); tick();
      chk_rd("be_rd_e2", 3'b110, 0, 32'hDE22BE44, 32'hDE22BE44);
      tick();
      chk_rd("be_rd_e3", 3'b000, 0, 0, 0);

      drv(1, 1, 6, 32'h600DF00D, 4'b1111, 0); tick();
      drv(1, 0, 6, 0, 0, 0); tick();
      chk_rd("wr_then_rd_e1", 3'b001, 32'h600DF00D, 0, 0);
      drv(0, 0, 0, 0, 0, 0); tick();
      chk_rd("wr_then_rd_e2", 3'b110, 0, 32'h600DF00D, 32'h600DF00D);

      for (int i = 0; i < 8; i++) begin
         drv(1, 1, 4'(i), 32'hC0DE0000 + 32'(i) * 32'h0101, 4'b1111, 0);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         drv(i < 8, 0, 4'(i), 0, 0, 0);
         tick();
         chk_rd($sformatf("b2b%0d", i), {i >= 1 && i <= 8, i >= 1 && i <= 8, i < 8},
                32'hC0DE0000 + 32'(i) * 32'h0101,
                32'hC0DE0000 + 32'(i - 1) * 32'h0101,
                32'hC0DE0000 + 32'(i - 1) * 32'h0101);
      end

      // clr with an accepted write; req stays high through the sweep
      drv(1, 1, 5, 32'hA5A5A5A5, 4'b1111, 1); tick();
      chk_st("clr_wr", 1'b0);
      for (int k = 1; k <= 16; k++) begin
         drv(1, k >= 8, 0, 32'hFFFFFFFF, 4'b1111, k == 5);
         tick();
         chk_st($sformatf("sweep%0d", k), k == 16);
         chk_rd($sformatf("sweep%0d", k), 3'b000, 0, 0, 0);
      end
      drv(1, 0, 5, 0, 0, 0); tick();
      chk_rd("clr_rd5", 3'b001, 32'h0, 0, 0);
      drv(1, 0, 0, 0, 0, 0); tick();
      chk_rd("clr_rd0", 3'b111, 32'h0, 32'h0, 32'h0);
      drv(0, 0, 0, 0, 0, 0); tick();
      chk_rd("clr_rd_tail", 3'b110, 0, 32'h0, 32'h0);

      // read of addr 0 in flight as the sweep clears addr 0
      drv(1, 1, 0, 32'h12345678, 4'b1111, 0); tick();
      drv(1, 0, 0, 0, 0, 1); tick();
      chk_rd("rdw_e1", 3'b001, 32'h12345678, 0, 0);
      chk_st("rdw_busy", 1'b0);
      drv(0, 0, 0, 0, 0, 0); tick();
      chk_rd("rdw_e2", 3'b110, 0, 32'h12345678, 32'h0);
      for (int k = 2; k <= 16; k++) begin
         tick();
         chk_st($sformatf("rdw_sweep%0d", k), k == 16);
      end

      // reset with a read in flight
      drv(1, 1, 3, 32'hCAFEF00D, 4'b1111, 0); tick();
      drv(1, 0, 3, 0, 0, 0); tick();
      chk_rd("pre_rst", 3'b001, 32'hCAFEF00D, 0, 0);
      drv(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk_rd("rst_rd", 3'b000, 0, 0, 0);
      for (int g = 0; g < 3; g++) chk($sformatf("rst_rd rdata%0d", g), rd[g], 32'h0);
      chk_st("rst_rd", 1'b0);
      tick();
      chk_rd("rst_rd2", 3'b000, 0, 0, 0);
      rst = 1'b0;

      // reset again at sweep cycle 7 with req held high
      for (int k = 1; k <= 7; k++) begin
         drv(1, 0, 3, 0, 0, 0);
         tick();
         chk_st($sformatf("pre7_%0d", k), 1'b0);
         chk_rd($sformatf("pre7_%0d", k), 3'b000, 0, 0, 0);
      end
      rst = 1'b1;
      tick(); tick();
      chk_st("rst7", 1'b0);
      chk_rd("rst7", 3'b000, 0, 0, 0);
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk_st($sformatf("resweep%0d", k), k == 16);
         chk_rd($sformatf("resweep%0d", k), 3'b000, 0, 0, 0);
      end
      tick();
      chk_rd("post_rst_rd_e1", 3'b001, 32'h0, 0, 0);
      drv(0, 0, 0, 0, 0, 0); tick();
      chk_rd("post_rst_rd_e2", 3'b110, 0, 32'h0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
